// File: rtl/dbus_pim_pkg.sv
// Shared constants and types for the darkriscv data-bus PIM responder:
// register offsets inside the 4 KB window, STATUS bit positions, read FSM states.
package dbus_pim_pkg;

    localparam logic [11:0] OFS_SRAM_END = 12'h400;
    localparam logic [11:0] OFS_CMD      = 12'h800;
    localparam logic [11:0] OFS_STATUS   = 12'h804;
    localparam logic [11:0] OFS_DONE     = 12'h808;

    localparam int ST_CNT_LSB  = 0;
    localparam int ST_CNT_W    = 4;
    localparam int ST_FULL     = 8;
    localparam int ST_EMPTY    = 9;
    localparam int ST_ERR      = 10;
    localparam int ST_DONE_LSB = 16;

    typedef enum logic {
        RD_IDLE,
        RD_WAIT
    } rd_state_e;

endpackage

// File: rtl/dbus_pim_responder_cmd_fifo.sv
// Synchronous command FIFO with a registered head word (no fall-through).
// A pop frees its slot in the same cycle, so push+pop while full is accepted.
module cmd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESN,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, rd_next;
    logic              do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + PW'(do_pop);

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PW'(do_push);
            count  <= count + CW'(do_push) - CW'(do_pop);
            // Head reloads from the array, or straight from din when the FIFO drains to nothing
            if (do_push && ((count - CW'(do_pop)) == '0))
                head <= din;
            else if (do_pop && (count > CW'(1)))
                head <= mem[rd_next];
        end
    end

endmodule

// File: rtl/dbus_pim_responder.sv
// Data-bus target for a 4 KB window: scratch SRAM, PIM command FIFO push port,
// STATUS and DONE_CNT registers. Reads and full-FIFO pushes stall the core via HLT.
module dbus_pim_responder
    import dbus_pim_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h0000_1000,
    parameter int          RAM_AW     = 8,
    parameter int          RD_LAT     = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [3:0]  BE,
    input  logic        WR,
    input  logic        RD,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [31:0] CMD_DATA,
    input  logic        DONE
);

    localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]  LAT3 = 3'(RD_LAT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              sel, wr_en, rd_req, is_sram;
    logic [11:0]       ofs;
    logic [RAM_AW-1:0] sram_idx;
    logic              cmd_wr, push_req, push_bad, push_hlt;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              err;
    logic [7:0]        done_cnt;
    logic [31:0]       status, src;
    logic [31:0]       sram [2**RAM_AW];

    assign sel      = (DADDR[31:12] == BASE[31:12]);
    assign ofs      = DADDR[11:0];
    assign wr_en    = WR && !RD && sel;
    assign rd_req   = RD && sel;
    assign is_sram  = (ofs < OFS_SRAM_END);
    assign sram_idx = DADDR[RAM_AW+1:2];

    assign cmd_wr   = wr_en && (ofs == OFS_CMD);
    assign push_req = cmd_wr && (BE == 4'hF);
    assign push_bad = cmd_wr && (BE != 4'hF);
    // Full implies non-empty, so CMD_READY alone means a slot frees this cycle
    assign push_hlt = push_req && fifo_full && !CMD_READY;

    always_ff @(posedge CLK) begin
        if (wr_en && is_sram)
            for (int i = 0; i < 4; i++)
                if (BE[i])
                    sram[sram_idx][8*i +: 8] <= DATAO[8*i +: 8];
    end

    cmd_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESN  (RESN),
        .push  (push_req),
        .din   (DATAO),
        .pop   (CMD_READY),
        .head  (CMD_DATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign CMD_VALID = !fifo_empty;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            err      <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (push_bad)
                err <= 1'b1;
            else if (wr_en && (ofs == OFS_STATUS) && DATAO[ST_ERR])
                err <= 1'b0;
            if (wr_en && (ofs == OFS_DONE))
                done_cnt <= {7'd0, DONE};
            else if (DONE)
                done_cnt <= sat_inc8(done_cnt);
        end
    end

    always_comb begin
        status = '0;
        status[ST_CNT_LSB +: ST_CNT_W] = 4'(fifo_count);
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_ERR]                 = err;
        status[ST_DONE_LSB +: 8]       = done_cnt;
    end

    always_comb begin
        src = '0;
        if (is_sram)
            src = sram[sram_idx];
        else if (ofs == OFS_STATUS)
            src = status;
        else if (ofs == OFS_DONE)
            src = {24'd0, done_cnt};
    end

    // Read stage: word captured on the first cycle, released after RD_LAT stall cycles
    rd_state_e   st, st_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        cap, rd_hlt, vld_p1;
    logic [31:0] rdata_p1;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            st  <= RD_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (cap)
            rdata_p1 <= src;
    end

    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        cap    = 1'b0;
        rd_hlt = 1'b0;
        vld_p1 = 1'b0;
        case (st)
            RD_IDLE: begin
                if (rd_req) begin
                    st_nx  = RD_WAIT;
                    cnt_nx = 3'd1;
                    cap    = 1'b1;
                    rd_hlt = 1'b1;
                end
            end
            RD_WAIT: begin
                if (!RD) begin
                    st_nx = RD_IDLE;
                end else if (cnt < LAT3) begin
                    rd_hlt = 1'b1;
                    cnt_nx = cnt + 3'd1;
                end else begin
                    vld_p1 = 1'b1;
                    st_nx  = RD_IDLE;
                end
            end
            default: st_nx = RD_IDLE;
        endcase
    end

    // Gating with RESN drops the stall the moment reset asserts
    assign HLT   = RESN && (rd_hlt || push_hlt);
    assign DATAI = vld_p1 ? rdata_p1 : '0;

endmodule

// File: tb/tb_dbus_pim_responder.sv
// Directed bench for dbus_pim_responder: two instances (RD_LAT=1 and 3) share the bus,
// each with its own RD; a transaction-level model is checked against both every cycle.
module tb_dbus_pim_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        CLK, RESN, WR, RD1, RD3, DONE, CMD_READY;
    logic [31:0] DADDR, DATAO;
    logic [3:0]  BE;
    logic [31:0] DATAI1, DATAI3, CMD_DATA1, CMD_DATA3;
    logic        HLT1, HLT3, CMD_VALID1, CMD_VALID3;

    int n_vec  = 0;
    int n_miss = 0;

    dbus_pim_responder #(.BASE(BASE), .RAM_AW(8), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u1 (
        .CLK(CLK), .RESN(RESN), .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .WR(WR), .RD(RD1),
        .DATAI(DATAI1), .HLT(HLT1), .CMD_VALID(CMD_VALID1), .CMD_READY(CMD_READY),
        .CMD_DATA(CMD_DATA1), .DONE(DONE));

    dbus_pim_responder #(.BASE(BASE), .RAM_AW(8), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) u3 (
        .CLK(CLK), .RESN(RESN), .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .WR(WR), .RD(RD3),
        .DATAI(DATAI3), .HLT(HLT3), .CMD_VALID(CMD_VALID3), .CMD_READY(CMD_READY),
        .CMD_DATA(CMD_DATA3), .DONE(DONE));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model state
    logic [31:0] m_sram [256];
    logic [31:0] m_q [$];
    logic        m_err;
    int          m_done;
    logic        m_busy [2];
    int          m_age  [2];
    logic [31:0] m_snap [2];

    function automatic logic [31:0] m_status();
        int s;
        s = m_q.size();
        return 32'(s) | ((s == DEPTH) ? 32'h100 : 32'h0) | ((s == 0) ? 32'h200 : 32'h0)
             | (m_err ? 32'h400 : 32'h0) | (32'(m_done) << 16);
    endfunction

    function automatic logic [31:0] m_read(input int ofs);
        if (ofs < 'h400)  return m_sram[ofs >> 2];
        if (ofs == 'h804) return m_status();
        if (ofs == 'h808) return 32'(m_done);
        return 32'h0;
    endfunction

    always @(negedge CLK) begin
        if (!RESN) begin
            chk("rst_hlt1", {31'd0, HLT1}, 32'd0);
            chk("rst_hlt3", {31'd0, HLT3}, 32'd0);
            chk("rst_datai1", DATAI1, 32'd0);
            chk("rst_datai3", DATAI3, 32'd0);
            chk("rst_cmd_valid", {31'd0, CMD_VALID1 | CMD_VALID3}, 32'd0);
            chk("rst_cmd_data", CMD_DATA1 | CMD_DATA3, 32'd0);
            m_q.delete();
            m_err  = 1'b0;
            m_done = 0;
            for (int k = 0; k < 2; k++) m_busy[k] = 1'b0;
        end else begin
            logic sel, pop, push_req, push_hlt, rdk, exp_h;
            logic [31:0] exp_d;
            int ofs, lat;
            sel      = (DADDR[31:12] == BASE[31:12]);
            ofs      = int'(DADDR[11:0]);
            pop      = (m_q.size() > 0) && CMD_READY;
            push_req = WR && sel && (ofs == 'h800) && (BE == 4'hF);
            push_hlt = push_req && (m_q.size() == DEPTH) && !pop;

            chk("cmd_valid1", {31'd0, CMD_VALID1}, {31'd0, m_q.size() > 0});
            chk("cmd_valid3", {31'd0, CMD_VALID3}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                chk("cmd_data1", CMD_DATA1, m_q[0]);
                chk("cmd_data3", CMD_DATA3, m_q[0]);
            end

            for (int k = 0; k < 2; k++) begin
                rdk   = (k == 0) ? RD1 : RD3;
                lat   = (k == 0) ? 1 : 3;
                exp_h = 1'b0;
                exp_d = 32'h0;
                if (rdk && m_busy[k]) begin
                    if (m_age[k] < lat) begin
                        exp_h = 1'b1;
                        m_age[k]++;
                    end else begin
                        exp_d     = m_snap[k];
                        m_busy[k] = 1'b0;
                    end
                end else if (rdk && sel) begin
                    m_snap[k] = m_read(ofs);
                    m_busy[k] = 1'b1;
                    m_age[k]  = 1;
                    exp_h     = 1'b1;
                end else begin
                    m_busy[k] = 1'b0;
                end
                if (k == 0) begin
                    chk("hlt1", {31'd0, HLT1}, {31'd0, exp_h | push_hlt});
                    chk("datai1", DATAI1, exp_d);
                end else begin
                    chk("hlt3", {31'd0, HLT3}, {31'd0, exp_h | push_hlt});
                    chk("datai3", DATAI3, exp_d);
                end
            end

            if (pop) void'(m_q.pop_front());
            if (push_req && !push_hlt) m_q.push_back(DATAO);
            if (WR && sel && (ofs == 'h800) && (BE != 4'hF)) m_err = 1'b1;
            if (WR && sel && (ofs == 'h804) && DATAO[10]) m_err = 1'b0;
            if (WR && sel && (ofs == 'h808)) m_done = DONE ? 1 : 0;
            else if (DONE && m_done < 255) m_done++;
            if (WR && sel && (ofs < 'h400))
                for (int b = 0; b < 4; b++)
                    if (BE[b]) m_sram[ofs >> 2][8*b +: 8] = DATAO[8*b +: 8];
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         output int st);
        DADDR = a; DATAO = d; BE = be; WR = 1'b1; st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!HLT1) break;
            st++;
        end
        if (st >= 20) begin
            n_miss++;
            $display("FAIL store_timeout: HLT held %0d cycles at %h, expected release", st, a);
        end
        @(posedge CLK); #1;
        WR = 1'b0; BE = 4'h0;
    endtask

    task automatic load(input int k, input logic [31:0] a, output logic [31:0] d, output int st);
        DADDR = a; st = 0; d = 32'h0;
        if (k == 1) RD1 = 1'b1; else RD3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (((k == 1) ? HLT1 : HLT3) == 1'b0) begin
                d = (k == 1) ? DATAI1 : DATAI3;
                break;
            end
            st++;
        end
        if (st >= 20) begin
            n_miss++;
            $display("FAIL load_timeout: HLT held %0d cycles at %h, expected release", st, a);
        end
        @(posedge CLK); #1;
        RD1 = 1'b0; RD3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int st, st2;
        RESN = 1'b0; WR = 1'b0; RD1 = 1'b0; RD3 = 1'b0; DONE = 1'b0; CMD_READY = 1'b0;
        DADDR = '0; DATAO = '0; BE = '0;
        cycles(3);
        RESN = 1'b1;
        cycles(1);

        // SRAM byte-enable merge
        store(BASE + 32'h10, 32'hDEADBEEF, 4'hF, st);
        chk("sram_wr_stall", st, 0);
        store(BASE + 32'h10, 32'h11223344, 4'b0101, st);
        load(1, BASE + 32'h10, d, st);
        chk("sram_merge", d, 32'hDE22BE44);
        chk("sram_rd_stall_lat1", st, 1);
        load(3, BASE + 32'h10, d, st);
        chk("sram_merge_lat3", d, 32'hDE22BE44);

        // STATUS after reset, latency per instance
        load(3, BASE + 32'h804, d, st);
        chk("status_empty_lat3", d, 32'h0000_0200);
        chk("status_stall_lat3", st, 3);
        load(1, BASE + 32'h804, d, st);
        chk("status_empty_lat1", d, 32'h0000_0200);
        load(3, BASE + 32'h900, d, st);
        chk("unmapped_rd", d, 32'h0);
        load(1, BASE + 32'h800, d, st);
        chk("cmd_rd_zero", d, 32'h0);
        load(3, 32'h0000_2010, d, st);
        chk("unsel_no_stall", st, 0);
        chk("unsel_data", d, 32'h0);

        // Fill FIFO, then a stalled push released by one pop
        for (int i = 0; i < 4; i++) begin
            store(BASE + 32'h800, 32'hA0 + 32'(i), 4'hF, st);
            chk("push_no_stall", st, 0);
        end
        load(3, BASE + 32'h804, d, st);
        chk("status_full", d, 32'h0000_0104);
        fork
            store(BASE + 32'h800, 32'hA4, 4'hF, st2);
            begin
                cycles(3);
                CMD_READY = 1'b1;
                @(negedge CLK);
                chk("head_at_pop", CMD_DATA1, 32'hA0);
                chk("hlt_drop_on_pop", {31'd0, HLT1}, 32'd0);
                cycles(1);
                CMD_READY = 1'b0;
            end
        join
        chk("full_push_stall", st2, 3);
        chk("head_after_pop", CMD_DATA1, 32'hA1);
        chk("model_qsize_4", m_q.size(), 4);
        load(1, BASE + 32'h804, d, st);
        chk("status_still_full", d, 32'h0000_0104);
        CMD_READY = 1'b1;
        cycles(4);
        CMD_READY = 1'b0;
        chk("drained_valid", {31'd0, CMD_VALID3}, 32'd0);

        // Partial-BE push sets sticky ERR; write-1 clears it
        store(BASE + 32'h800, 32'hB0, 4'hF, st);
        store(BASE + 32'h800, 32'hB1, 4'h3, st);
        chk("bad_push_no_stall", st, 0);
        load(1, BASE + 32'h804, d, st);
        chk("status_err", d, 32'h0000_0401);
        chk("head_b0", CMD_DATA1, 32'hB0);
        store(BASE + 32'h804, 32'h0000_0400, 4'hF, st);
        load(3, BASE + 32'h804, d, st);
        chk("status_err_clr", d, 32'h0000_0001);

        // DONE_CNT saturation and clear-vs-increment
        DONE = 1'b1;
        cycles(260);
        DONE = 1'b0;
        load(3, BASE + 32'h808, d, st);
        chk("done_sat", d, 32'h0000_00FF);
        load(1, BASE + 32'h804, d, st);
        chk("status_done", d, 32'h00FF_0001);
        DADDR = BASE + 32'h808; DATAO = 32'h0; BE = 4'hF; WR = 1'b1; DONE = 1'b1;
        cycles(1);
        WR = 1'b0; DONE = 1'b0; BE = 4'h0;
        load(1, BASE + 32'h808, d, st);
        chk("done_clr_with_pulse", d, 32'h1);
        store(BASE + 32'h808, 32'h0, 4'h1, st);
        load(3, BASE + 32'h808, d, st);
        chk("done_clr", d, 32'h0);

        // Reset during a full-FIFO push stall
        for (int i = 1; i < 4; i++) store(BASE + 32'h800, 32'hB0 + 32'(i), 4'hF, st);
        chk("model_qsize_full", m_q.size(), 4);
        DADDR = BASE + 32'h800; DATAO = 32'hB4; BE = 4'hF; WR = 1'b1;
        @(negedge CLK);
        chk("stall_before_rst", {31'd0, HLT1}, 32'd1);
        @(negedge CLK);
        #2 RESN = 1'b0;
        #1;
        chk("rst_async_hlt1", {31'd0, HLT1}, 32'd0);
        chk("rst_async_hlt3", {31'd0, HLT3}, 32'd0);
        chk("rst_async_valid", {31'd0, CMD_VALID1}, 32'd0);
        cycles(1);
        WR = 1'b0; BE = 4'h0;
        cycles(2);
        RESN = 1'b1;
        cycles(1);
        load(3, BASE + 32'h804, d, st);
        chk("status_after_rst", d, 32'h0000_0200);
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dbus_pim_responder.md
# dbus_pim_responder

Memory-mapped responder on the darkriscv core's data bus (DADDR/DATAO/DATAI/BE/WR/RD/HLT) that owns a 4 KB window: a local scratch SRAM, a command FIFO feeding the PIM array controller, and a status/done-count register. It is the target side of the CPU's load/store interface. It stretches reads and full-FIFO command pushes by driving the core's HLT input. It sits between the core and the PIM controller, in parallel with the general data RAM.

## Interface
- BASE, 32'h0000_1000: window base, 4 KB aligned; window = BASE..BASE+0xFFF.
- RAM_AW, 8: scratch SRAM word-address width (2^RAM_AW words, at most 256).
- RD_LAT, 1: read stall cycles, legal range 1..7.
- FIFO_DEPTH, 4: command FIFO entries, power of two, ≥2.
- CLK  in  1  clock; all state updates on the rising edge.
- RESN  in  1  asynchronous, active-low reset.
- DADDR  in  32  byte address from the core.
- DATAO  in  32  write data from the core.
- BE  in  4  byte enables for writes.
- WR  in  1  write strobe.
- RD  in  1  read strobe.
- DATAI  out  32  read data to the core.
- HLT  out  1  stall request to the core, combinational from state and bus inputs.
- CMD_VALID  out  1  FIFO head valid toward the PIM controller.
- CMD_READY  in  1  PIM controller accepts the head.
- CMD_DATA  out  32  FIFO head word.
- DONE  in  1  one-cycle pulse per completed PIM command.

## Operation
- Select: sel = (DADDR[31:12] == BASE[31:12]). Offset = DADDR[11:0]. WR and RD are never asserted together; if they are, the write is ignored.
- Address map:
  - 0x000–0x3FF: SRAM, word index DADDR[RAM_AW+1:2].
  - 0x800: CMD push (write-only; reads return 0).
  - 0x804: STATUS (read-only).
  - 0x808: DONE_CNT (read; any write clears it).
  - Unmapped offsets read 0; writes to them are ignored.
- SRAM write: single cycle, no stall; BE[i] gates byte i. SRAM contents are not reset.
- CMD push: honoured only when BE==4'hF. A partial-BE push is dropped and sets the sticky ERR bit.
  - FIFO not full: push in the same cycle, no stall.
  - FIFO full: HLT=1 until a pop frees a slot; the push completes in the cycle HLT drops.
- FIFO pop: on CMD_VALID && CMD_READY. Push and pop in the same cycle leave the count unchanged, which is legal even when full, since the pop frees the slot.
- STATUS bits:
  - [3:0] FIFO count.
  - [8] full.
  - [9] empty.
  - [10] ERR, sticky; cleared by a write to 0x804 with DATAO[10]=1.
  - [23:16] DONE_CNT.
- DONE_CNT: 8-bit counter, +1 per DONE, saturates at 255. A clear write in the same cycle as DONE yields 1.
- Read FSM has two states:
  - IDLE: RD&&sel → WAIT, cnt=1, HLT=1, source word captured into the read register.
  - WAIT: while cnt<RD_LAT, HLT=1 and cnt++. When cnt==RD_LAT, HLT=0, DATAI=read register, return to IDLE at the next edge.
  - If RD drops while in WAIT, return to IDLE and drop HLT.
- Read data is sampled at the first cycle of the read. Status changes during the stall are not reflected.
- DATAI = 0 whenever no read is completing.

## Timing
- Reset values:
  - HLT=0, DATAI=0, CMD_VALID=0, CMD_DATA=0.
  - FSM in IDLE, FIFO empty, DONE_CNT=0, ERR=0.
- Reset asserted mid-read or mid-stall: HLT drops immediately (asynchronous) and any pending push is lost.
- Read latency: HLT is high for exactly RD_LAT cycles; data is valid in cycle RD_LAT+1.
- CMD_VALID goes high the cycle after the first push into an empty FIFO.
- CMD_DATA is the registered head word; no fall-through.

## Structure
- Package dbus_pim_pkg holds:
  - offset constants OFS_CMD=12'h800, OFS_STATUS=12'h804, OFS_DONE=12'h808;
  - STATUS bit-position constants;
  - the read FSM state enum.
- Sub-module cmd_fifo, a synchronous FIFO (push/pop/full/empty/count, registered head).
- The SRAM is inferred inline.

## Test plan
- Store 0xDEADBEEF to BASE+0x10 with BE=4'hF, then with BE=4'b0101 and DATAO=0x11223344; load BASE+0x10 → HLT high 1 cycle (RD_LAT=1), DATAI=0xDE22BE44.
- RD_LAT=3: load BASE+0x804 with FIFO empty → HLT high 3 cycles, DATAI=0x0000_0200.
- Push 4 commands 0xA0..0xA3 with CMD_READY=0, then push 0xA4 → HLT held. Raise CMD_READY one cycle → CMD_DATA=0xA0 popped, HLT drops, count stays 4, head becomes 0xA1.
- Push with BE=4'h3 → FIFO unchanged, STATUS[10]=1; write 0x804 with DATAO=0x400 → ERR=0.
- Pulse DONE 260 times → DONE_CNT=255. Write 0x808 in the same cycle as a DONE pulse → DONE_CNT=1.
- Deassert RESN while HLT is high during a full-FIFO push → HLT=0 immediately, CMD_VALID=0, STATUS reads 0x200 after reset.
